instr_prefetch: RTL and testbench

- Instruction fetch front end; sits directly upstream of the Cpu decode/execute core.
- Host side of the instruction-memory Avalon-MM read port, issuing pipelined word reads from a running fetch PC.
- Buffers returned words with their PCs in a small FIFO and presents them to the core over a valid/ready handshake.
- Core redirects (branch/jump/trap) flush the buffer; in-flight responses are discarded.

---
 rtl/instr_prefetch_pkg.sv | 17 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/instr_prefetch.sv | 148 ++++++++++++++
 tb/tb_instr_prefetch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared types for the instruction prefetch front end.
package instr_prefetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD_STALE
  } prefetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word, flush and occupancy count.
// Shared between the instruction prefetcher and the load/store unit.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rptr;
  logic [AW-1:0]    r_wptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_rptr_inc;

  assign full       = (r_count == (AW+1)'(DEPTH));
  assign empty      = (r_count == '0);
  assign count      = r_count;
  assign head       = r_head;
  assign w_do_pop   = pop && !empty;
  assign w_do_push  = push && (!full || w_do_pop);
  assign w_rptr_inc = r_rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= push_data;
  end

  // r_head always mirrors the entry that is at the read pointer after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else if (flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= w_rptr_inc;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
      if (w_do_pop) begin
        if (r_count > (AW+1)'(1))  r_head <= r_mem[w_rptr_inc];
        else if (w_do_push)        r_head <= push_data;
      end else if (empty && w_do_push) begin
        r_head <= push_data;
      end
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction fetch front end: pipelined Avalon-MM word reads from a running PC,
// credit-limited buffering, and redirect handling that discards stale responses.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  prefetch_state_t r_state;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_resp_pc;
  logic [31:0]     r_avm_address;
  logic            r_avm_read;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;

  logic            w_accept;
  logic            w_keep;
  logic            w_pop;
  logic            w_credit;
  logic [31:0]     w_redir_pc;
  logic [31:0]     w_fetch_pc_next;
  logic [CW-1:0]   w_out_next;
  logic [CW-1:0]   w_fifo_cnt_next;
  logic [CW:0]     w_credit_sum;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  assign w_accept     = r_avm_read && !avm_waitrequest;
  assign w_keep       = avm_readdatavalid && (r_discard == '0) && !redirect_valid;
  assign w_pop        = !w_fifo_empty && out_ready;
  assign w_redir_pc   = {redirect_pc[31:2], 2'b00};
  assign w_push_entry = '{pc: r_resp_pc, instr: avm_readdata};

  assign w_fetch_pc_next = redirect_valid                  ? w_redir_pc :
                           (w_accept && r_state == REQ)    ? r_fetch_pc + 32'(INSTR_BYTES) :
                                                             r_fetch_pc;

  // Credit is judged on the occupancy this cycle leaves behind.
  assign w_out_next      = r_outstanding + CW'(w_accept) - CW'(avm_readdatavalid);
  assign w_fifo_cnt_next = redirect_valid ? '0
                                          : w_fifo_count + CW'(w_keep) - CW'(w_pop);
  assign w_credit_sum    = {1'b0, w_out_next} + {1'b0, w_fifo_cnt_next};
  assign w_credit        = (w_credit_sum < (CW+1)'(DEPTH)) && !(w_fifo_full && !w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_avm_read    <= 1'b0;
      r_avm_address <= RESET_PC;
    end else begin
      r_fetch_pc    <= w_fetch_pc_next;
      r_outstanding <= w_out_next;

      if (redirect_valid)  r_resp_pc <= w_redir_pc;
      else if (w_keep)     r_resp_pc <= r_resp_pc + 32'(INSTR_BYTES);

      // A redirect disowns everything still in flight, including this cycle's accept.
      if (redirect_valid)
        r_discard <= w_out_next;
      else
        r_discard <= r_discard + CW'(w_accept && r_state == HOLD_STALE)
                               - CW'(avm_readdatavalid && r_discard != '0);

      case (r_state)
        IDLE: begin
          if (w_credit) begin
            r_state       <= REQ;
            r_avm_read    <= 1'b1;
            r_avm_address <= w_fetch_pc_next;
          end
        end
        REQ: begin
          if (!w_accept) begin
            if (redirect_valid) r_state <= HOLD_STALE;
          end else if (w_credit) begin
            r_avm_address <= w_fetch_pc_next;
          end else begin
            r_state    <= IDLE;
            r_avm_read <= 1'b0;
          end
        end
        HOLD_STALE: begin
          if (w_accept) begin
            if (w_credit) begin
              r_state       <= REQ;
              r_avm_address <= w_fetch_pc_next;
            end else begin
              r_state    <= IDLE;
              r_avm_read <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_avm_read <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_keep),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count),
    .head      (w_head)
  );

  assign avm_read    = r_avm_read;
  assign avm_address = r_avm_address;
  assign out_valid   = !w_fifo_empty;
  assign out_pc      = w_head.pc;
  assign out_instr   = w_head.instr;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch against an in-order, latency-1 Avalon agent.
module tb_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  logic        hold_rsp;
  logic [31:0] last_acc;
  logic [31:0] rq[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  instr_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .out_valid         (out_valid),
    .out_pc            (out_pc),
    .out_instr         (out_instr),
    .out_ready         (out_ready)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory agent: answers each accepted read one cycle later unless hold_rsp is set.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rq.delete();
      avm_readdatavalid <= 1'b0;
      avm_readdata      <= '0;
      last_acc          <= '0;
    end else begin
      if (avm_read && !avm_waitrequest) begin
        rq.push_back(avm_address);
        last_acc <= avm_address;
      end
      if (!hold_rsp && rq.size() > 0) begin
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= mem(rq.pop_front());
      end else begin
        avm_readdatavalid <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid  = 1'b0;
    avm_waitrequest = 1'b0;
    out_ready       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst             = 1'b1;
    avm_waitrequest = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    out_ready       = 1'b1;
    hold_rsp        = 1'b0;
    @(negedge clk);

    chk("rst_read",  32'(avm_read),  32'd0);
    chk("rst_addr",  avm_address,    32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc",    out_pc,         32'h0);
    chk("rst_instr", out_instr,      32'h0);

    // Streaming with a zero-wait agent.
    rst = 1'b0;
    tick();
    chk("t1_read0", 32'(avm_read), 32'd1);
    chk("t1_addr0", avm_address,   32'h0);
    chk("t1_nv0",   32'(out_valid), 32'd0);
    tick();
    chk("t1_addr1", avm_address,    32'h4);
    chk("t1_nv1",   32'(out_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_pc0",   out_pc,         32'h0);
    chk("t1_ins0",  out_instr,      mem(32'h0));
    chk("t1_addr2", avm_address,    32'h8);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("t1_pc",   out_pc,      32'(4 * k));
      chk("t1_ins",  out_instr,   mem(32'(4 * k)));
      chk("t1_addr", avm_address, 32'(4 * k + 8));
    end

    // Back-pressure: credit stops issue once four words are owned.
    out_ready = 1'b0;
    repeat (5) tick();
    chk("t2_read_off", 32'(avm_read),  32'd0);
    chk("t2_last_acc", last_acc,       32'd24);
    chk("t2_valid",    32'(out_valid), 32'd1);
    chk("t2_pc_hold",  out_pc,         32'd12);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_valid_s", 32'(out_valid), 32'd1);
      chk("t2_pc_s",    out_pc,         32'(12 + 4 * i));
      chk("t2_ins_s",   out_instr,      mem(32'(12 + 4 * i)));
      tick();
    end

    // Redirect with reads outstanding and their responses held back.
    hold_rsp = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    chk("t3_addr8", avm_address, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("t3_read",  32'(avm_read),  32'd1);
    chk("t3_addr",  avm_address,    32'h100);
    chk("t3_nv",    32'(out_valid), 32'd0);
    hold_rsp = 1'b0;
    wait_valid("t3_wait");
    chk("t3_pc",    out_pc,    32'h100);
    chk("t3_ins",   out_instr, mem(32'h100));
    tick();
    chk("t3_pc2",   out_pc,    32'h104);
    chk("t3_ins2",  out_instr, mem(32'h104));

    // Redirect while the request at 0x8 is stalled.
    do_reset();
    tick();
    tick();
    tick();
    chk("t4_addr8", avm_address, 32'h8);
    avm_waitrequest = 1'b1;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h106;
    tick();
    redirect_valid  = 1'b0;
    chk("t4_read",  32'(avm_read),  32'd1);
    chk("t4_hold0", avm_address,    32'h8);
    chk("t4_nv",    32'(out_valid), 32'd0);
    tick();
    chk("t4_hold1", avm_address,    32'h8);
    avm_waitrequest = 1'b0;
    tick();
    chk("t4_newaddr", avm_address,  32'h104);
    wait_valid("t4_wait");
    chk("t4_pc",    out_pc,    32'h104);
    chk("t4_ins",   out_instr, mem(32'h104));

    // Redirect coinciding with a response and an output handshake.
    do_reset();
    tick();
    tick();
    tick();
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("t5_nv",    32'(out_valid), 32'd0);
    chk("t5_read",  32'(avm_read),  32'd1);
    chk("t5_addr",  avm_address,    32'h200);
    wait_valid("t5_wait");
    chk("t5_pc",    out_pc,    32'h200);
    chk("t5_ins",   out_instr, mem(32'h200));

    // Asynchronous reset in the middle of a burst.
    out_ready = 1'b0;
    hold_rsp  = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_read",  32'(avm_read),  32'd0);
    chk("t6_addr",  avm_address,    32'h0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_pc",    out_pc,         32'h0);
    chk("t6_ins",   out_instr,      32'h0);
    hold_rsp  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t6_restart_rd", 32'(avm_read), 32'd1);
    chk("t6_restart",    avm_address,   32'h0);
    wait_valid("t6_wait");
    chk("t6_pc0",   out_pc,    32'h0);
    chk("t6_ins0",  out_instr, mem(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
